register_bank: RTL and testbench
================================

Name: register_bank

Overview:
- Register file of the 8-bit processor datapath: one accumulator (ACC) plus four general-purpose registers R0..R3.
- Feeds the ALU its two operands (ACC on alu_acc_out, a selected GPR on alu_B_out).
- Drives a selected GPR onto the internal data bus (bank_data_out).
- Accepts writes from the bus, from the ALU result, or as register-to-register copies.

Parameters:
- WIDTH, 8, data width of every register and data port. Select widths stay fixed for any WIDTH.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  reset, asynchronous, active-low; clears all registers
- acc_sel  input  1  ACC write enable; 1 loads acc_data_in at the clock edge
- destination_sel  input  4  one-hot GPR write enables; bit0=R0, bit1=R1, bit2=R2, bit3=R3
- source_sel  input  3  selects the data written into the GPRs enabled by destination_sel
- alu_b_sel  input  2  selects the GPR driven on alu_B_out (00=R0 .. 11=R3)
- bank_out_sel  input  2  selects the GPR driven on bank_data_out (00=R0 .. 11=R3)
- bank_data_in  input  WIDTH  data from the bus or immediate
- acc_data_in  input  WIDTH  ALU result destined for ACC
- bank_data_out  output  WIDTH  selected GPR to the bus
- alu_acc_out  output  WIDTH  ACC contents to ALU operand A
- alu_B_out  output  WIDTH  selected GPR to ALU operand B

Behaviour:
- Reset: reset low clears ACC and R0..R3 to 0 immediately, independent of clk, so all three outputs read 0. Reset dominates any write in the same cycle. Registers hold 0 until the first rising edge after reset returns high.
- ACC: on the rising edge, if acc_sel=1 then ACC <= acc_data_in; otherwise ACC holds.
- GPR write data source (source_sel):
  - 000 = bank_data_in
  - 001 = R0
  - 010 = R1
  - 011 = R2
  - 100 = ACC
  - 101 = R3
  - 110 and 111 = all zeros
- GPR write: on the rising edge, every Rn whose destination_sel bit is 1 loads the selected source. Rn holds when its bit is 0. destination_sel=0000 writes nothing.
- Several destination bits set: all enabled registers load the same value in the same edge.
- Read-before-write: sources and outputs use register values from before the edge.
  - Register-to-register copies take the pre-edge value (a self-copy is a no-op).
  - A GPR write from ACC in the same cycle as an ACC load stores the old ACC value.
- Outputs:
  - All three outputs are combinational reads of register state. No internal write-to-read bypass.
  - A written value appears on the outputs in the cycle after the write edge (one-edge latency).
  - alu_acc_out = ACC. alu_B_out = R[alu_b_sel]. bank_data_out = R[bank_out_sel].
- X-free: every select encoding is fully decoded. There are no latches.

Decomposition:
- Shared package holds:
  - source_sel encodings: SRC_BUS, SRC_R0, SRC_R1, SRC_R2, SRC_ACC, SRC_R3, SRC_ZERO.
  - GPR index constants R0..R3 and destination one-hot masks.
  - The default WIDTH.
- One sub-module, bank_reg: a WIDTH-bit register with a load enable and asynchronous active-low clear.
  - Instantiated five times: ACC and R0..R3.
- Source, ALU-B and bus-out multiplexers live in the top level.

Test Plan:
- Reset: hold reset=0 with acc_sel=1 and destination_sel=1111 -> all outputs 00. Pulse reset low mid-cycle after loads -> outputs drop to 00 before the next edge.
- Bus load: bank_data_in=AA, source_sel=000, destination_sel=0001, one edge; then destination_sel=0000, bank_out_sel=00, alu_b_sel=00 -> bank_data_out=AA, alu_B_out=AA; R1..R3 remain 00.
- ACC load/hold: acc_data_in=55, acc_sel=1, one edge -> alu_acc_out=55. Then acc_sel=0, acc_data_in=FF, edge -> alu_acc_out stays 55.
- ACC to GPR: ACC=55, source_sel=100, destination_sel=0100, edge -> alu_b_sel=10 gives 55. Same cycle with acc_sel=1, acc_data_in=77 -> R2=55 (old ACC), ACC=77.
- Copy and broadcast: R0=AA, source_sel=001, destination_sel=1110, edge -> R1=R2=R3=AA, checked through both output muxes on all four selects.
- Zero source: source_sel=110, destination_sel=0001, edge -> R0=00. destination_sel=0000 for several edges -> no register changes.

Source files
------------

// File: rtl/register_bank_pkg.sv
// Shared definitions for the datapath register bank: data width, GPR write-source
// encodings, and GPR index / destination-mask constants.
package register_bank_pkg;

  localparam int DEFAULT_WIDTH = 8;
  localparam int NUM_GPR       = 4;

  // Encodings of source_sel. 3'b110 and 3'b111 both select zero.
  typedef enum logic [2:0] {
    SRC_BUS  = 3'b000,
    SRC_R0   = 3'b001,
    SRC_R1   = 3'b010,
    SRC_R2   = 3'b011,
    SRC_ACC  = 3'b100,
    SRC_R3   = 3'b101,
    SRC_ZERO = 3'b110
  } src_sel_e;

  localparam logic [1:0] R0 = 2'd0;
  localparam logic [1:0] R1 = 2'd1;
  localparam logic [1:0] R2 = 2'd2;
  localparam logic [1:0] R3 = 2'd3;

  localparam logic [3:0] DST_NONE = 4'b0000;
  localparam logic [3:0] DST_R0   = 4'b0001;
  localparam logic [3:0] DST_R1   = 4'b0010;
  localparam logic [3:0] DST_R2   = 4'b0100;
  localparam logic [3:0] DST_R3   = 4'b1000;
  localparam logic [3:0] DST_ALL  = 4'b1111;

endpackage

// File: rtl/register_bank_bank_reg.sv
// Single WIDTH-bit register with load enable and asynchronous active-low clear;
// used for the accumulator and each general-purpose register.
module bank_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out
);

  logic [WIDTH-1:0] data_d;
  logic [WIDTH-1:0] data_q;

  // NOTE: default-assign first so every path drives data_d and no latch is inferred.
  always_comb begin
    data_d = data_q;
    if (load) begin
      data_d = data_in;
    end
  end

  // NOTE: non-blocking assignment so all bank registers sample pre-edge values together.
  // NOTE: each register is a plain flop with its own async clear; no RAM array exists to leave uncleared.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign data_out = data_q;

endmodule

// File: rtl/register_bank.sv
// Accumulator plus R0..R3 register file: selects GPR write data, and drives ALU
// operands and the bus read port straight from register state.
module register_bank
  import register_bank_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             acc_sel,
  input  logic [3:0]       destination_sel,
  input  logic [2:0]       source_sel,
  input  logic [1:0]       alu_b_sel,
  input  logic [1:0]       bank_out_sel,
  input  logic [WIDTH-1:0] bank_data_in,
  input  logic [WIDTH-1:0] acc_data_in,
  output logic [WIDTH-1:0] bank_data_out,
  output logic [WIDTH-1:0] alu_acc_out,
  output logic [WIDTH-1:0] alu_B_out
);

  logic [WIDTH-1:0] acc_val;
  logic [WIDTH-1:0] gpr_val [NUM_GPR];
  logic [WIDTH-1:0] gpr_src;

  bank_reg #(.WIDTH(WIDTH)) u_acc (
    .clk      (clk),
    .reset    (reset),
    .load     (acc_sel),
    .data_in  (acc_data_in),
    .data_out (acc_val)
  );

  // All enabled GPRs share one source value; sources are pre-edge register contents.
  for (genvar g = 0; g < NUM_GPR; g++) begin : g_gpr
    bank_reg #(.WIDTH(WIDTH)) u_gpr (
      .clk      (clk),
      .reset    (reset),
      .load     (destination_sel[g]),
      .data_in  (gpr_src),
      .data_out (gpr_val[g])
    );
  end

  always_comb begin
    gpr_src = '0;
    case (source_sel)
      SRC_BUS: gpr_src = bank_data_in;
      SRC_R0:  gpr_src = gpr_val[R0];
      SRC_R1:  gpr_src = gpr_val[R1];
      SRC_R2:  gpr_src = gpr_val[R2];
      SRC_ACC: gpr_src = acc_val;
      SRC_R3:  gpr_src = gpr_val[R3];
      default: gpr_src = '0;
    endcase
  end

  assign alu_acc_out   = acc_val;
  assign alu_B_out     = gpr_val[alu_b_sel];
  assign bank_data_out = gpr_val[bank_out_sel];

endmodule

// File: tb/tb_register_bank.sv
// Directed and randomized bench for register_bank against an array-based model
// of ACC and R0..R3.
module tb_register_bank;

  logic       clk;
  logic       reset;
  logic       acc_sel;
  logic [3:0] destination_sel;
  logic [2:0] source_sel;
  logic [1:0] alu_b_sel;
  logic [1:0] bank_out_sel;
  logic [7:0] bank_data_in;
  logic [7:0] acc_data_in;
  logic [7:0] bank_data_out;
  logic [7:0] alu_acc_out;
  logic [7:0] alu_B_out;

  int checks = 0;
  int errors = 0;

  logic [7:0] acc_m;
  logic [7:0] r_m [4];

  register_bank #(.WIDTH(8)) dut (
    .clk             (clk),
    .reset           (reset),
    .acc_sel         (acc_sel),
    .destination_sel (destination_sel),
    .source_sel      (source_sel),
    .alu_b_sel       (alu_b_sel),
    .bank_out_sel    (bank_out_sel),
    .bank_data_in    (bank_data_in),
    .acc_data_in     (acc_data_in),
    .bank_data_out   (bank_data_out),
    .alu_acc_out     (alu_acc_out),
    .alu_B_out       (alu_B_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Model: all writes use values from before the edge; source table by encoding.
  task automatic tick();
    logic [7:0] srcv [8];
    logic [7:0] nr [4];
    logic [7:0] na;
    srcv = '{bank_data_in, r_m[0], r_m[1], r_m[2], acc_m, r_m[3], 8'h00, 8'h00};
    na = acc_sel ? acc_data_in : acc_m;
    for (int i = 0; i < 4; i++) nr[i] = destination_sel[i] ? srcv[source_sel] : r_m[i];
    @(posedge clk);
    #1;
    acc_m = na;
    r_m   = nr;
  endtask

  task automatic idle();
    acc_sel         = 1'b0;
    destination_sel = 4'b0000;
    source_sel      = 3'b000;
  endtask

  task automatic check_model(input string tag);
    #1;
    check({tag, "_acc"}, alu_acc_out, acc_m);
    check({tag, "_b"}, alu_B_out, r_m[alu_b_sel]);
    check({tag, "_bus"}, bank_data_out, r_m[bank_out_sel]);
  endtask

  initial begin
    reset = 1'b0; acc_sel = 1'b1; destination_sel = 4'b1111; source_sel = 3'b000;
    alu_b_sel = 2'd0; bank_out_sel = 2'd1; bank_data_in = 8'h3C; acc_data_in = 8'hC3;
    acc_m = 8'h00;
    for (int i = 0; i < 4; i++) r_m[i] = 8'h00;

    // Reset held through edges with all write enables asserted.
    repeat (2) @(posedge clk);
    #1;
    check("rst_acc", alu_acc_out, 8'h00);
    check("rst_b", alu_B_out, 8'h00);
    check("rst_bus", bank_data_out, 8'h00);
    idle();
    reset = 1'b1;

    // Bus load into R0.
    bank_data_in = 8'hAA; source_sel = 3'b000; destination_sel = 4'b0001;
    tick();
    idle(); bank_out_sel = 2'd0; alu_b_sel = 2'd0;
    #1;
    check("bus_ld_bus", bank_data_out, 8'hAA);
    check("bus_ld_b", alu_B_out, 8'hAA);
    for (int k = 1; k < 4; k++) begin
      bank_out_sel = k[1:0];
      #1 check("bus_ld_other", bank_data_out, 8'h00);
    end

    // ACC load then hold.
    acc_data_in = 8'h55; acc_sel = 1'b1;
    tick();
    check("acc_ld", alu_acc_out, 8'h55);
    acc_sel = 1'b0; acc_data_in = 8'hFF;
    tick();
    check("acc_hold", alu_acc_out, 8'h55);

    // ACC to R2 while ACC reloads: R2 gets the old ACC.
    source_sel = 3'b100; destination_sel = 4'b0100; acc_sel = 1'b1; acc_data_in = 8'h77;
    tick();
    idle(); alu_b_sel = 2'd2;
    #1;
    check("acc2gpr_r2", alu_B_out, 8'h55);
    check("acc2gpr_acc", alu_acc_out, 8'h77);

    // Broadcast R0 into R1..R3.
    source_sel = 3'b001; destination_sel = 4'b1110;
    tick();
    idle();
    for (int k = 0; k < 4; k++) begin
      alu_b_sel = k[1:0]; bank_out_sel = 2'(3 - k);
      #1;
      check("bcast_b", alu_B_out, 8'hAA);
      check("bcast_bus", bank_data_out, 8'hAA);
    end

    // Self-copy is a no-op.
    source_sel = 3'b011; destination_sel = 4'b1000; bank_data_in = 8'h12;
    tick();
    idle(); alu_b_sel = 2'd3;
    #1 check("r3_from_r2", alu_B_out, 8'hAA);
    source_sel = 3'b001; destination_sel = 4'b0001;
    tick();
    idle(); alu_b_sel = 2'd0;
    #1 check("self_copy", alu_B_out, 8'hAA);

    // Zero sources, then idle edges.
    source_sel = 3'b110; destination_sel = 4'b0001;
    tick();
    source_sel = 3'b111; destination_sel = 4'b0010;
    tick();
    idle(); alu_b_sel = 2'd0; bank_out_sel = 2'd1;
    #1;
    check("zero_r0", alu_B_out, 8'h00);
    check("zero_r1", bank_data_out, 8'h00);
    bank_data_in = 8'hEE; acc_data_in = 8'hEE;
    repeat (3) tick();
    for (int k = 0; k < 4; k++) begin
      alu_b_sel = k[1:0];
      #1 check("idle_hold", alu_B_out, r_m[k]);
    end
    check("idle_acc", alu_acc_out, 8'h77);

    // Randomized sequence.
    for (int n = 0; n < 400; n++) begin
      acc_sel         = 1'($urandom);
      destination_sel = 4'($urandom);
      source_sel      = 3'($urandom);
      bank_data_in    = 8'($urandom);
      acc_data_in     = 8'($urandom);
      tick();
      alu_b_sel    = 2'($urandom);
      bank_out_sel = 2'($urandom);
      check_model("rand");
    end

    // Async reset mid-cycle after loads clears outputs before the next edge.
    acc_sel = 1'b1; acc_data_in = 8'h9D; source_sel = 3'b000; bank_data_in = 8'h6B;
    destination_sel = 4'b1111;
    tick();
    idle(); alu_b_sel = 2'd1; bank_out_sel = 2'd2;
    #1 check("pre_rst_b", alu_B_out, 8'h6B);
    #1 reset = 1'b0;
    #1;
    check("mid_rst_acc", alu_acc_out, 8'h00);
    check("mid_rst_b", alu_B_out, 8'h00);
    check("mid_rst_bus", bank_data_out, 8'h00);
    reset = 1'b1;
    acc_m = 8'h00;
    for (int i = 0; i < 4; i++) r_m[i] = 8'h00;
    tick();
    check_model("post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
